// File: rtl/tune_sequencer.sv
// Data-driven buzzer melody sequencer: fetches NOTE/REST/END entries from a synchronous ROM.
// Optional SEQ_ARTIC_GAP_EN mutes the tail of each note by GAP_CYCLES.
module tune_sequencer #(
  parameter int unsigned TICK_CYCLES = 4_500_000,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned GAP_CYCLES  = 450_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic [12:0]       tone_freq,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  if (TICK_CYCLES < 2 || GAP_CYCLES >= TICK_CYCLES) begin : g_bad_params
    $error("tune_sequencer: need TICK_CYCLES >= 2 and GAP_CYCLES < TICK_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [12:0]       tone_freq_q, tone_freq_d;
  logic              tone_en_q, tone_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [4:0]        dur_cnt_q, dur_cnt_d;

  logic [1:0]  op;
  logic [4:0]  dur;
  logic [12:0] freq;
  logic        tick_wrap;
  logic        take_end;

  assign op        = rom_data[19:18];
  assign dur       = rom_data[17:13];
  assign freq      = rom_data[12:0];
  assign tick_wrap = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    tone_freq_d = tone_freq_q;
    tone_en_d   = tone_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    take_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (op[1]) begin
          take_end = 1'b1;
        end else begin
          if (op == 2'b00) begin
            tone_freq_d = freq;
            tone_en_d   = (freq != '0);
          end else begin
            tone_en_d = 1'b0;
          end
          dur_cnt_d  = (dur == '0) ? 5'd1 : dur;
          tick_cnt_d = '0;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_wrap) begin
          tick_cnt_d = '0;
          dur_cnt_d  = dur_cnt_q - 5'd1;
          if (dur_cnt_q == 5'd1) begin
            tone_en_d = 1'b0;
            // Running off the top of the ROM behaves exactly like an END entry.
            if (rom_addr_q == '1) begin
              take_end = 1'b1;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = S_FETCH;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
`ifdef SEQ_ARTIC_GAP_EN
          // Registered output: drop enable one cycle early so the last GAP_CYCLES are muted.
          if (dur_cnt_q == 5'd1 && tick_cnt_q == TICK_W'(TICK_CYCLES - GAP_CYCLES - 1))
            tone_en_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_end) begin
      if (loop_en) begin
        rom_addr_d = '0;
        state_d    = S_FETCH;
      end else begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end

    if (stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      tone_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      tone_freq_q <= '0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_cnt_q  <= '0;
      dur_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      tone_freq_q <= tone_freq_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tick_cnt_q  <= tick_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign tone_freq = tone_freq_q;
  assign tone_en   = tone_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench for tune_sequencer: expected tone segments and done pulses are queued per test.
module tb_tune_sequencer;
  localparam int TICK = 10;
  localparam int GAPC = 3;
  localparam int AW   = 4;
`ifdef SEQ_ARTIC_GAP_EN
  localparam int G = GAPC;
`else
  localparam int G = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [19:0]   rom_data;
  logic [12:0]   tone_freq;
  logic          tone_en, busy, done;

  tune_sequencer #(.TICK_CYCLES(TICK), .ADDR_W(AW), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone_freq(tone_freq),
    .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int st; int len; int freq; } seg_t;
  seg_t seg_q[$];
  int   done_q[$];
  seg_t exp_seg;
  int   t0 = 0;
  bit   prev_en = 1'b0;
  int   seg_st = 0;
  int   seg_f = 0;
  bit   freq_bad = 1'b0;

  always @(negedge clk) begin
    if (tone_en && !prev_en) begin
      seg_st   = cyc - t0;
      seg_f    = int'(tone_freq);
      freq_bad = 1'b0;
    end else if (tone_en && int'(tone_freq) != seg_f) begin
      freq_bad = 1'b1;
    end
    if (!tone_en && prev_en) begin
      if (seg_q.size() == 0) begin
        check("unexpected_seg_start", seg_st, -1);
      end else begin
        exp_seg = seg_q.pop_front();
        check("seg_start", seg_st, exp_seg.st);
        check("seg_len", cyc - t0 - seg_st, exp_seg.len);
        check("seg_freq", seg_f, exp_seg.freq);
        check("freq_stable", int'(freq_bad), 0);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", cyc - t0, -1);
      else check("done_cycle", cyc - t0, done_q.pop_front());
    end
    prev_en = tone_en;
  end

  function automatic logic [19:0] ent(input logic [1:0] op, input int dur, input int f);
    return {op, 5'(dur), 13'(f)};
  endfunction

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = ent(2'b10, 0, 0);
  endtask

  task automatic load_basic();
    clear_rom();
    rom[0] = ent(2'b00, 2, 659);
    rom[1] = ent(2'b00, 1, 523);
    rom[2] = ent(2'b10, 0, 0);
  endtask

  task automatic push_seg(input int st, input int len, input int f);
    seg_t s;
    s.st = st; s.len = len; s.freq = f;
    seg_q.push_back(s);
  endtask

  task automatic go();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic at(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic finish_test();
    check("seg_q_empty", seg_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    seg_q.delete();
    done_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clear_rom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_tone_freq", int'(tone_freq), 0);
    check("rst_tone_en", int'(tone_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic playback
    load_basic();
    push_seg(3, 2*TICK - G, 659);
    push_seg(25, TICK - G, 523);
    done_q.push_back(37);
    go();
    at(10);
    check("basic_busy", int'(busy), 1);
    at(37);
    check("basic_busy_at_done", int'(busy), 0);
    at(40);
    check("basic_busy_after", int'(busy), 0);
    finish_test();

    // rest with zero duration
    clear_rom();
    rom[0] = ent(2'b01, 0, 0);
    rom[1] = ent(2'b00, 1, 784);
    push_seg(15, TICK - G, 784);
    done_q.push_back(27);
    go();
    at(8);
    check("rest_tone_en", int'(tone_en), 0);
    check("rest_busy", int'(busy), 1);
    at(30);
    finish_test();

    // loop, then drop loop_en
    load_basic();
    loop_en = 1'b1;
    push_seg(3, 2*TICK - G, 659);
    push_seg(25, TICK - G, 523);
    push_seg(39, 2*TICK - G, 659);
    push_seg(61, TICK - G, 523);
    done_q.push_back(73);
    go();
    at(50);
    loop_en = 1'b0;
    at(76);
    check("loop_busy_after", int'(busy), 0);
    finish_test();

    // stop mid-note
    load_basic();
    push_seg(3, 8, 659);
    go();
    at(10);
    stop = 1'b1;
    at(11);
    stop = 1'b0;
    check("stop_tone_en", int'(tone_en), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    at(20);
    check("stop_busy_later", int'(busy), 0);
    finish_test();

    // start while busy
    load_basic();
    push_seg(3, 2*TICK - G, 659);
    push_seg(25, TICK - G, 523);
    done_q.push_back(37);
    go();
    at(28);
    check("busy_start_addr_before", int'(rom_addr), 1);
    start = 1'b1;
    at(29);
    start = 1'b0;
    check("busy_start_addr_after", int'(rom_addr), 1);
    at(40);
    finish_test();

    // reset mid-note
    load_basic();
    push_seg(3, 2*TICK - G, 659);
    push_seg(25, 4, 523);
    go();
    at(28);
    rst = 1'b1;
    at(29);
    rst = 1'b0;
    check("rstmid_tone_en", int'(tone_en), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_rom_addr", int'(rom_addr), 0);
    check("rstmid_tone_freq", int'(tone_freq), 0);
    check("rstmid_done", int'(done), 0);
    at(35);
    finish_test();

    // start and stop together in idle
    load_basic();
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("ss_busy_later", int'(busy), 0);
    check("ss_tone_en", int'(tone_en), 0);
    finish_test();

    // address wrap without END
    for (int i = 0; i < 16; i++) begin
      rom[i] = ent(2'b00, 1, 100 + 10*i);
      push_seg(3 + 12*i, TICK - G, 100 + 10*i);
    end
    done_q.push_back(193);
    go();
    at(196);
    check("wrap_busy_after", int'(busy), 0);
    finish_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
